// File: rtl/mmio_bus_bridge_pkg.sv
// Shared decode constants and read-source select for the MMIO bus bridge.
package mmio_bus_bridge_pkg;
  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] IO_CNT  = 18'h30004;

  typedef enum logic [2:0] {
    SEL_RAM, SEL_RX, SEL_CNT0, SEL_CNT1, SEL_CNT2, SEL_CNT3, SEL_ZERO, SEL_ONES
  } sel_e;
endpackage

// File: rtl/mmio_tx_fifo.sv
// Synchronous FIFO for UART TX bytes; push when full is dropped, pop still proceeds.
module mmio_tx_fifo #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   count,
  output logic [AW:0]   count_next,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          do_push, do_pop;

  assign count      = wptr - rptr;
  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rdata      = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/mmio_bus_bridge.sv
// CPU byte-bus decoder: RAM vs I/O window, UART TX/RX, cycle counter, program stop.
// Optional MMIO_TRAP_UNMAPPED_EN: 0x20000-0x2FFFF flags unmapped_err, blocks writes, reads 0xFF.
module mmio_bus_bridge
  import mmio_bus_bridge_pkg::*;
#(
  parameter int TX_WIDTH    = 3,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_halt
`ifdef MMIO_TRAP_UNMAPPED_EN
  ,
  output logic        unmapped_err
`endif
);
  localparam int DEPTH = 1 << TX_WIDTH;

  logic [17:0]       addr;
  logic              io, unmapped, acc, rd_rx, rd_cnt, push, set_stop;
  logic [7:0]        push_data;
  logic [31:0]       cycle_cnt, snap;
  logic [7:0]        rx_q;
  logic              stop_q;
  sel_e              sel_q, sel_nxt;
  logic [TX_WIDTH:0] fifo_count, fifo_count_next;
  logic              fifo_full, fifo_empty;
  logic              unused_bits;

  assign addr        = cpu_a[17:0];
  assign io          = (addr[17:16] == 2'b11);
`ifdef MMIO_TRAP_UNMAPPED_EN
  assign unmapped    = (addr[17:16] == 2'b10);
`else
  assign unmapped    = 1'b0;
`endif
  assign unused_bits = ^{cpu_a[31:18], fifo_count, fifo_full};

  // Reset also masks the combinational strobes so nothing escapes during reset.
  assign acc      = rdy_in & ~rst_in;
  assign ram_a    = addr[16:0];
  assign ram_dout = cpu_dout;
  assign ram_wr   = acc & cpu_wr & ~io & ~unmapped;
  assign rd_rx    = acc & ~cpu_wr & (addr == IO_BASE);
  assign rd_cnt   = acc & ~cpu_wr & (addr == IO_CNT);
  assign rx_pop   = rd_rx & rx_valid;
  assign set_stop = acc & cpu_wr & (addr == IO_CNT);
  assign push     = set_stop | (acc & cpu_wr & (addr == IO_BASE) & (cpu_dout != 8'h00));
  assign push_data = set_stop ? 8'h00 : cpu_dout;
  assign tx_valid = ~fifo_empty;

  always_comb begin
    sel_nxt = SEL_ZERO;
    if (!cpu_wr) begin
      if (unmapped)  sel_nxt = SEL_ONES;
      else if (!io)  sel_nxt = SEL_RAM;
      else begin
        case (addr)
          IO_BASE:          sel_nxt = SEL_RX;
          IO_CNT:           sel_nxt = SEL_CNT0;
          IO_CNT + 18'd1:   sel_nxt = SEL_CNT1;
          IO_CNT + 18'd2:   sel_nxt = SEL_CNT2;
          IO_CNT + 18'd3:   sel_nxt = SEL_CNT3;
          default:          sel_nxt = SEL_ZERO;
        endcase
      end
    end
  end

  always_comb begin
    cpu_din = 8'h00;
    case (sel_q)
      SEL_RAM:  cpu_din = ram_din;
      SEL_RX:   cpu_din = rx_q;
      SEL_CNT0: cpu_din = snap[7:0];
      SEL_CNT1: cpu_din = snap[15:8];
      SEL_CNT2: cpu_din = snap[23:16];
      SEL_CNT3: cpu_din = snap[31:24];
      SEL_ONES: cpu_din = 8'hFF;
      default:  cpu_din = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_cnt      <= '0;
      snap           <= '0;
      rx_q           <= '0;
      sel_q          <= SEL_ZERO;
      stop_q         <= 1'b0;
      program_halt   <= 1'b0;
      io_buffer_full <= 1'b0;
    end else begin
      if (rdy_in) begin
        cycle_cnt <= cycle_cnt + 32'd1;
        sel_q     <= sel_nxt;
      end
      if (rd_rx)    rx_q <= rx_valid ? rx_data : 8'h00;
      if (rd_cnt)   snap <= cycle_cnt;
      if (set_stop) stop_q <= 1'b1;
      program_halt   <= program_halt | (stop_q & fifo_empty);
      // Registered from next-state count so the CPU sees it one cycle early enough.
      io_buffer_full <= (DEPTH - int'(fifo_count_next)) <= FULL_MARGIN;
    end
  end

`ifdef MMIO_TRAP_UNMAPPED_EN
  always_ff @(posedge clk_in) begin
    if (rst_in)              unmapped_err <= 1'b0;
    else if (acc & unmapped) unmapped_err <= 1'b1;
  end
`endif

  mmio_tx_fifo #(.AW(TX_WIDTH), .DW(8)) u_tx_fifo (
    .clk        (clk_in),
    .rst        (rst_in),
    .push       (push),
    .pop        (tx_valid & tx_ready),
    .wdata      (push_data),
    .rdata      (tx_data),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );
endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Bench for mmio_bus_bridge: queue/array reference model checked every cycle, plus literal checks.
module tb_mmio_bus_bridge;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, cpu_wr, tx_ready, rx_valid;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout, rx_data, ram_din;
  logic [7:0]  cpu_din, ram_dout, tx_data;
  logic [16:0] ram_a;
  logic        io_buffer_full, ram_wr, tx_valid, rx_pop, program_halt;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_bus_bridge dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .cpu_a(cpu_a),
    .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .io_buffer_full(io_buffer_full), .ram_a(ram_a), .ram_wr(ram_wr),
    .ram_dout(ram_dout), .ram_din(ram_din), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_pop(rx_pop), .program_halt(program_halt)
  );

  always #5 clk_in = ~clk_in;

  // External RAM with 1-cycle read latency
  logic [7:0] ram [0:131071];
  always @(posedge clk_in) begin
    if (ram_wr) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [7:0]  shadow [0:131071];
  logic [7:0]  q[$];
  bit          m_live = 0;
  logic [31:0] m_cnt, m_snap;
  logic [7:0]  m_din;
  bit          m_dchk, m_stop, m_halt, m_full;
  bit          was_empty, was_full;
  logic [17:0] ma;

  always @(posedge clk_in) begin
    if (rst_in) begin
      q.delete();
      m_cnt = 0; m_snap = 0; m_din = 0; m_dchk = 1;
      m_stop = 0; m_halt = 0; m_full = 0; m_live = 1;
    end else if (m_live) begin
      was_empty = (q.size() == 0);
      was_full  = (q.size() == 8);
      ma = cpu_a[17:0];
      m_halt = m_halt | (m_stop & was_empty);
      if (!was_empty && tx_ready) void'(q.pop_front());
      if (rdy_in) begin
        m_dchk = !cpu_wr;
        if (cpu_wr) begin
          if (ma[17:16] != 2'b11) shadow[ma[16:0]] = cpu_dout;
          else if (ma == 18'h30000 && cpu_dout != 8'h00) begin
            if (!was_full) q.push_back(cpu_dout);
          end else if (ma == 18'h30004) begin
            if (!was_full) q.push_back(8'h00);
            m_stop = 1;
          end
        end else begin
          if (ma[17:16] != 2'b11) m_din = shadow[ma[16:0]];
          else if (ma == 18'h30000) m_din = rx_valid ? rx_data : 8'h00;
          else if (ma >= 18'h30004 && ma <= 18'h30007) begin
            if (ma == 18'h30004) m_snap = m_cnt;
            m_din = m_snap[8*ma[1:0] +: 8];
          end else m_din = 8'h00;
        end
        m_cnt = m_cnt + 1;
      end else m_dchk = 0;
      m_full = (8 - q.size()) <= 2;
    end
  end

  always @(negedge clk_in) begin
    if (m_live) begin
      chk("ram_wr", ram_wr, rdy_in & cpu_wr & ~rst_in & (cpu_a[17:16] != 2'b11));
      chk("ram_a", ram_a, cpu_a[16:0]);
      chk("rx_pop", rx_pop, rdy_in & ~cpu_wr & ~rst_in & (cpu_a[17:0] == 18'h30000) & rx_valid);
      if (m_dchk) chk("cpu_din", cpu_din, m_din);
      chk("tx_valid", tx_valid, q.size() != 0);
      if (q.size() != 0) chk("tx_data", tx_data, q[0]);
      chk("io_buffer_full", io_buffer_full, m_full);
      chk("program_halt", program_halt, m_halt);
    end
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
    rdy_in = r; cpu_wr = w; cpu_a = a; cpu_dout = d;
  endtask
  task automatic idle(); drive(1'b1, 1'b0, 32'h3FF00, 8'h00); endtask
  task automatic tick(); @(posedge clk_in); #1; endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] got[$];
  logic [7:0] hv[$];
  logic [7:0] vv[$];
  int e;

  initial begin
    for (int i = 0; i < 131072; i++) begin ram[i] = 8'h00; shadow[i] = 8'h00; end
    rst_in = 1; tx_ready = 0; rx_valid = 0; rx_data = 8'h00;
    drive(1'b1, 1'b1, 32'h00020, 8'h77);
    tick(); tick();
    chk("rst cpu_din", cpu_din, 8'h00);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst io_buffer_full", io_buffer_full, 1'b0);
    chk("rst program_halt", program_halt, 1'b0);
    chk("rst ram_wr", ram_wr, 1'b0);
    chk("rst rx_pop", rx_pop, 1'b0);
    rst_in = 0; idle();

    // Counter snapshot: after 0x12345 ready cycles the count is 0x12345
    for (int i = 0; i < 32'h12345; i++) tick();
    drive(1'b1, 1'b0, 32'h30004, 8'h00); tick(); chk("cnt byte0", cpu_din, 8'h45);
    drive(1'b1, 1'b0, 32'h30005, 8'h00); tick(); chk("cnt byte1", cpu_din, 8'h23);
    drive(1'b1, 1'b0, 32'h30006, 8'h00); tick(); chk("cnt byte2", cpu_din, 8'h01);
    drive(1'b1, 1'b0, 32'h30007, 8'h00); tick(); chk("cnt byte3", cpu_din, 8'h00);
    drive(1'b0, 1'b0, 32'h30004, 8'h00); tick(); tick();
    drive(1'b1, 1'b0, 32'h30005, 8'h00); tick(); chk("cnt hold", cpu_din, 8'h23);

    // Single TX byte, then zero byte ignored
    tx_ready = 1;
    drive(1'b1, 1'b1, 32'h30000, 8'h41); tick();
    chk("tx 41 valid", tx_valid, 1'b1);
    chk("tx 41 data", tx_data, 8'h41);
    idle(); tick();
    drive(1'b1, 1'b1, 32'h30000, 8'h00); tick();
    chk("tx zero ignored", tx_valid, 1'b0);

    // Fill to near-full, overflow, drain in order
    tx_ready = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 32'h30000, 8'h10 + 8'(i)); tick();
      if (i == 4) chk("full after 5", io_buffer_full, 1'b0);
      if (i == 5) chk("full after 6", io_buffer_full, 1'b1);
    end
    idle(); tick();
    tx_ready = 1;
    got.delete();
    for (int i = 0; i < 20; i++) begin
      if (tx_valid) got.push_back(tx_data);
      tick();
    end
    chk("drain count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("drain order", got[i], 8'h10 + 8'(i));

    // RX pop
    rx_valid = 1; rx_data = 8'h5A;
    drive(1'b1, 1'b0, 32'h30000, 8'h00); #1;
    chk("rx_pop pulse", rx_pop, 1'b1);
    tick(); chk("rx data", cpu_din, 8'h5A);
    rx_valid = 0; idle(); #1;
    chk("rx_pop after", rx_pop, 1'b0);
    drive(1'b1, 1'b0, 32'h30000, 8'h00); #1;
    chk("rx_pop empty", rx_pop, 1'b0);
    tick(); chk("rx empty data", cpu_din, 8'h00);

    // RAM write / readback, frozen write
    drive(1'b1, 1'b1, 32'h00010, 8'h9C); #1;
    chk("ram_wr on", ram_wr, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'h00010, 8'h00); tick(); chk("ram readback", cpu_din, 8'h9C);
    drive(1'b0, 1'b1, 32'h00020, 8'h55); #1;
    chk("ram_wr frozen", ram_wr, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h00020, 8'h00); tick(); chk("ram untouched", cpu_din, 8'h00);

    // Stop: two queued bytes then 0x00, halt one cycle after empty
    tx_ready = 0;
    drive(1'b1, 1'b1, 32'h30000, 8'hAA); tick();
    drive(1'b1, 1'b1, 32'h30000, 8'hBB); tick();
    drive(1'b1, 1'b1, 32'h30004, 8'h77); tick();
    idle(); tx_ready = 1;
    got.delete(); hv.delete(); vv.delete();
    for (int i = 0; i < 12; i++) begin
      if (tx_valid) got.push_back(tx_data);
      vv.push_back(8'(tx_valid)); hv.push_back(8'(program_halt));
      tick();
    end
    chk("stop count", got.size(), 3);
    if (got.size() == 3) begin
      chk("stop b0", got[0], 8'hAA);
      chk("stop b1", got[1], 8'hBB);
      chk("stop b2", got[2], 8'h00);
    end
    e = -1;
    for (int i = 0; i < vv.size(); i++) if (e < 0 && vv[i] == 0) e = i;
    chk("empty seen", e >= 0 && e < 11, 1'b1);
    if (e >= 0 && e < 11) begin
      chk("halt at empty", hv[e], 8'h00);
      chk("halt after empty", hv[e+1], 8'h01);
    end

    // Reset mid-transfer
    tx_ready = 0;
    drive(1'b1, 1'b1, 32'h30000, 8'h33); tick();
    drive(1'b1, 1'b0, 32'h00010, 8'h00); rst_in = 1; tick();
    chk("midrst tx_valid", tx_valid, 1'b0);
    chk("midrst cpu_din", cpu_din, 8'h00);
    chk("midrst halt", program_halt, 1'b0);
    rst_in = 0; idle(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
